// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
//
// Shared definitions for the MDU arbiter slice:
//   - default operand/result width (XLEN_DEFAULT)
//   - MDU operation codes, MUL..REMU, in the RISC-V M-extension funct3 order
//   - arbiter FSM state encoding
//   - small helper for picking the other port of a two-port arbiter
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Operation codes presented on req_op*/mdu_operation.
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  // Arbiter sequencing states. Exactly one operation is outstanding at a time:
  // IDLE accepts, ISSUE pulses start, WAIT holds operands until done, RESP
  // holds the result until the winning requester consumes it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Port index opposite to the given one (two-port arbiter).
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage : mdu_pkg

// File: rtl/mdu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mdu_rr_arbiter
//
// Purely combinational 2-way grant selection.
//   - A single valid port always wins.
//   - With both ports valid:
//       FIXED_PRIO = 0 : round-robin, the port that was NOT served last wins.
//       FIXED_PRIO = 1 : port 0 always wins.
//
// Ports:
//   i_req_valid   [1:0] per-port request valid (bit i = port i)
//   i_last_grant        port served by the most recently completed operation
//   o_grant_valid       at least one port is requesting
//   o_grant             index of the winning port (meaningful with o_grant_valid)
// -----------------------------------------------------------------------------
module mdu_rr_arbiter
  import mdu_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] i_req_valid,
  input  logic       i_last_grant,
  output logic       o_grant_valid,
  output logic       o_grant
);

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_grant_valid = |i_req_valid;
    o_grant       = 1'b0;
    case (i_req_valid)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = FIXED_PRIO ? 1'b0 : other_port(i_last_grant);
      default: o_grant = 1'b0;
    endcase
  end

endmodule : mdu_rr_arbiter

// File: rtl/mdu_arbiter.sv
// -----------------------------------------------------------------------------
// mdu_arbiter
//
// Shares one multi-cycle multiply/divide unit between two requesters. Requests
// arrive over valid/ready, one is granted (round-robin or fixed priority), its
// operands are latched, the MDU is started with a one-cycle pulse, and the
// result is returned on the winner's response channel. Only one operation is
// in flight; no new request is accepted until the response is consumed.
//
// Optional build macro:
//   MDU_RESULT_CACHE_EN - remember the last completed {op, x, y, result}; an
//                         accepted request that matches skips the MDU and
//                         responds one cycle after accept.
//
// Parameters:
//   XLEN        operand/result width
//   FIXED_PRIO  0 = round-robin on ties, 1 = port 0 always wins ties
//
// Ports:
//   clk                  clock
//   reset                asynchronous active-low reset
//   req_valid  [1:0]     per-port request valid
//   req_ready  [1:0]     per-port request accepted this cycle (IDLE only)
//   req_op0/1  [2:0]     operation code per port
//   req_x0/1   [XLEN]    rs1 operand per port
//   req_y0/1   [XLEN]    rs2 operand per port
//   rsp_valid  [1:0]     per-port response valid
//   rsp_ready  [1:0]     per-port response consumed
//   rsp_result [XLEN]    shared result bus, meaningful for the port with rsp_valid
//   mdu_start            one-cycle start pulse to the MDU
//   mdu_operation [2:0]  operation to the MDU
//   mdu_x/mdu_y [XLEN]   operands to the MDU
//   mdu_done             MDU completion (sampled only in WAIT)
//   mdu_result [XLEN]    MDU result
// -----------------------------------------------------------------------------
module mdu_arbiter
  import mdu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2:0]      req_op0,
  input  logic [2:0]      req_op1,
  input  logic [XLEN-1:0] req_x0,
  input  logic [XLEN-1:0] req_x1,
  input  logic [XLEN-1:0] req_y0,
  input  logic [XLEN-1:0] req_y1,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            mdu_start,
  output logic [2:0]      mdu_operation,
  output logic [XLEN-1:0] mdu_x,
  output logic [XLEN-1:0] mdu_y,
  input  logic            mdu_done,
  input  logic [XLEN-1:0] mdu_result
);

  // ---------------------------------------------------------------------------
  // State and holding registers
  // ---------------------------------------------------------------------------
  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic            r_grant;       // port owning the in-flight operation
  logic            r_last_grant;  // port served by the last completed response
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_x;
  logic [XLEN-1:0] r_y;
  logic [XLEN-1:0] r_result;

  // ---------------------------------------------------------------------------
  // Arbitration and request mux
  // ---------------------------------------------------------------------------
  logic            w_grant_valid;
  logic            w_grant;
  logic [2:0]      w_sel_op;
  logic [XLEN-1:0] w_sel_x;
  logic [XLEN-1:0] w_sel_y;
  logic            w_accept;
  logic            w_rsp_done;
  logic            w_mdu_finish;
  logic            w_hit;

  mdu_rr_arbiter #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_rr_arbiter (
    .i_req_valid   (req_valid),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  assign w_sel_op = w_grant ? req_op1 : req_op0;
  assign w_sel_x  = w_grant ? req_x1  : req_x0;
  assign w_sel_y  = w_grant ? req_y1  : req_y0;

  assign w_accept     = (r_state == ST_IDLE) && w_grant_valid;
  // Only the granted port's rsp_ready completes the response.
  assign w_rsp_done   = (r_state == ST_RESP) && rsp_ready[r_grant];
  // A done outside WAIT (e.g. during ISSUE) is not ours to consume.
  assign w_mdu_finish = (r_state == ST_WAIT) && mdu_done;

  // ---------------------------------------------------------------------------
  // Optional result cache
  // ---------------------------------------------------------------------------
`ifdef MDU_RESULT_CACHE_EN
  logic            r_c_valid;
  logic [2:0]      r_c_op;
  logic [XLEN-1:0] r_c_x;
  logic [XLEN-1:0] r_c_y;
  logic [XLEN-1:0] r_c_result;

  assign w_hit = r_c_valid && (r_c_op == w_sel_op) &&
                 (r_c_x == w_sel_x) && (r_c_y == w_sel_y);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c_valid  <= 1'b0;
      r_c_op     <= '0;
      r_c_x      <= '0;
      r_c_y      <= '0;
      r_c_result <= '0;
    end else if (w_mdu_finish) begin
      // The holding registers still carry the operands of the finishing op.
      r_c_valid  <= 1'b1;
      r_c_op     <= r_op;
      r_c_x      <= r_x;
      r_c_y      <= r_y;
      r_c_result <= mdu_result;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    mdu_start   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          req_ready[w_grant] = 1'b1;
          w_state_nxt        = w_hit ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mdu_start   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mdu_done) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[r_grant] = 1'b1;
        if (rsp_ready[r_grant]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, result capture, fairness pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;  // port 0 wins the first tie
      r_op         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_result     <= '0;
    end else begin
      if (w_accept) begin
        r_grant <= w_grant;
        r_op    <= w_sel_op;
        r_x     <= w_sel_x;
        r_y     <= w_sel_y;
      end
`ifdef MDU_RESULT_CACHE_EN
      if (w_accept && w_hit) begin
        r_result <= r_c_result;
      end
`endif
      if (w_mdu_finish) begin
        r_result <= mdu_result;
      end
      // Fairness only advances once the served port has taken its result.
      if (w_rsp_done) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // Operands come straight from the holding registers, so they are stable
  // from ISSUE through WAIT without any extra enable.
  assign mdu_operation = r_op;
  assign mdu_x         = r_x;
  assign mdu_y         = r_y;
  assign rsp_result    = r_result;

endmodule : mdu_arbiter

// File: tb/tb_mdu_arbiter.sv
`timescale 1ns/1ps
module tb_mdu_arbiter;
  import mdu_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Index 0: round-robin instance, index 1: fixed-priority instance.
  logic [1:0]      req_valid [2];
  logic [1:0]      req_ready [2];
  logic [2:0]      req_op0   [2];
  logic [2:0]      req_op1   [2];
  logic [XLEN-1:0] req_x0    [2];
  logic [XLEN-1:0] req_x1    [2];
  logic [XLEN-1:0] req_y0    [2];
  logic [XLEN-1:0] req_y1    [2];
  logic [1:0]      rsp_valid [2];
  logic [1:0]      rsp_ready [2];
  logic [XLEN-1:0] rsp_result[2];
  logic            mdu_start [2];
  logic [2:0]      mdu_operation[2];
  logic [XLEN-1:0] mdu_x     [2];
  logic [XLEN-1:0] mdu_y     [2];
  logic            mdu_done  [2];
  logic [XLEN-1:0] mdu_result[2];

  int mdu_lat;
  int total = 0;
  int bad   = 0;

  mdu_arbiter #(.XLEN(XLEN), .FIXED_PRIO(0)) u_dut_rr (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid[0]),
    .req_ready     (req_ready[0]),
    .req_op0       (req_op0[0]),
    .req_op1       (req_op1[0]),
    .req_x0        (req_x0[0]),
    .req_x1        (req_x1[0]),
    .req_y0        (req_y0[0]),
    .req_y1        (req_y1[0]),
    .rsp_valid     (rsp_valid[0]),
    .rsp_ready     (rsp_ready[0]),
    .rsp_result    (rsp_result[0]),
    .mdu_start     (mdu_start[0]),
    .mdu_operation (mdu_operation[0]),
    .mdu_x         (mdu_x[0]),
    .mdu_y         (mdu_y[0]),
    .mdu_done      (mdu_done[0]),
    .mdu_result    (mdu_result[0])
  );

  mdu_arbiter #(.XLEN(XLEN), .FIXED_PRIO(1)) u_dut_fp (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid[1]),
    .req_ready     (req_ready[1]),
    .req_op0       (req_op0[1]),
    .req_op1       (req_op1[1]),
    .req_x0        (req_x0[1]),
    .req_x1        (req_x1[1]),
    .req_y0        (req_y0[1]),
    .req_y1        (req_y1[1]),
    .rsp_valid     (rsp_valid[1]),
    .rsp_ready     (rsp_ready[1]),
    .rsp_result    (rsp_result[1]),
    .mdu_start     (mdu_start[1]),
    .mdu_operation (mdu_operation[1]),
    .mdu_x         (mdu_x[1]),
    .mdu_y         (mdu_y[1]),
    .mdu_done      (mdu_done[1]),
    .mdu_result    (mdu_result[1])
  );

  // Reference arithmetic for the MDU model (RISC-V M semantics).
  function automatic logic [31:0] mdu_ref(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] ps;
    logic        [63:0] pu;
    logic        [31:0] r;
    r  = '0;
    ps = '0;
    pu = '0;
    case (op)
      MDU_MUL:    r = a * b;
      MDU_MULH:   begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = ps[63:32]; end
      MDU_MULHSU: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});       r = ps[63:32]; end
      MDU_MULHU:  begin pu = {32'd0, a} * {32'd0, b};                                 r = pu[63:32]; end
      MDU_DIV:    if (b == 0) r = '1;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                  else r = $signed(a) / $signed(b);
      MDU_DIVU:   r = (b == 0) ? '1 : a / b;
      MDU_REM:    if (b == 0) r = a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                  else r = $signed(a) % $signed(b);
      default:    r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Behavioural MDU per instance: done pulses mdu_lat cycles after start.
  for (genvar k = 0; k < 2; k++) begin : g_mdu
    logic            done;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] pend;
    logic            busy;
    int              cnt;
    int              n_start;
    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        done    <= 1'b0;
        res     <= '0;
        pend    <= '0;
        busy    <= 1'b0;
        cnt     <= 0;
        n_start <= 0;
      end else begin
        done <= 1'b0;
        if (mdu_start[k]) begin
          n_start <= n_start + 1;
          if (mdu_lat <= 1) begin
            done <= 1'b1;
            res  <= mdu_ref(mdu_operation[k], mdu_x[k], mdu_y[k]);
          end else begin
            busy <= 1'b1;
            cnt  <= mdu_lat - 1;
            pend <= mdu_ref(mdu_operation[k], mdu_x[k], mdu_y[k]);
          end
        end else if (busy) begin
          if (cnt <= 1) begin
            busy <= 1'b0;
            done <= 1'b1;
            res  <= pend;
          end else begin
            cnt <= cnt - 1;
          end
        end
      end
    end
    assign mdu_done[k]   = done;
    assign mdu_result[k] = res;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    check({tag, " req_ready"},  32'(req_ready[d]),     32'd0);
    check({tag, " rsp_valid"},  32'(rsp_valid[d]),     32'd0);
    check({tag, " mdu_start"},  32'(mdu_start[d]),     32'd0);
    check({tag, " mdu_op"},     32'(mdu_operation[d]), 32'd0);
    check({tag, " mdu_x"},      mdu_x[d],              32'd0);
    check({tag, " mdu_y"},      mdu_y[d],              32'd0);
    check({tag, " rsp_result"}, rsp_result[d],         32'd0);
  endtask

  // Steps until rsp_valid[d][p] rises, bounded; n = cycles stepped.
  task automatic wait_rsp(input int d, input int p, output int n);
    n = 0;
    while (rsp_valid[d][p] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("rsp_valid arrives", 32'(rsp_valid[d][p]), 32'd1);
  endtask

  task automatic consume(input int d, input int p);
    rsp_ready[d]    = 2'b00;
    rsp_ready[d][p] = 1'b1;
    step();
    check("rsp_valid cleared", 32'(rsp_valid[d]), 32'd0);
    rsp_ready[d] = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int starts_before;
    reset   = 1'b0;
    mdu_lat = 3;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 2'b00;
      rsp_ready[d] = 2'b00;
      req_op0[d]   = '0;
      req_op1[d]   = '0;
      req_x0[d]    = '0;
      req_x1[d]    = '0;
      req_y0[d]    = '0;
      req_y1[d]    = '0;
    end
    step();
    step();
    check_reset_vals(0, "reset rr");
    check_reset_vals(1, "reset fp");
    reset = 1'b1;
    step();

    // ---- Port 0 MUL 6*7, MDU done 3 cycles after start --------------------
    req_op0[0] = MDU_MUL; req_x0[0] = 32'd6; req_y0[0] = 32'd7;
    req_valid[0] = 2'b01;
    #1;
    check("t1 req_ready", 32'(req_ready[0]), 32'h1);
    step();
    req_valid[0] = 2'b00;
    check("t1 mdu_start", 32'(mdu_start[0]), 32'd1);
    check("t1 mdu_op", 32'(mdu_operation[0]), 32'(MDU_MUL));
    check("t1 mdu_x", mdu_x[0], 32'd6);
    check("t1 mdu_y", mdu_y[0], 32'd7);
    wait_rsp(0, 0, n);
    check("t1 latency", n, 32'd4);
    check("t1 rsp_valid", 32'(rsp_valid[0]), 32'h1);
    check("t1 result", rsp_result[0], 32'd42);
    step();
    step();
    check("t1 hold valid", 32'(rsp_valid[0]), 32'h1);
    check("t1 hold result", rsp_result[0], 32'd42);
    check("t1 one start", g_mdu[0].n_start, 32'd1);
    consume(0, 0);

    reset = 1'b0;
    step();
    reset = 1'b1;
    step();

    // ---- Tie, round-robin: DIV 100/7 then REM 100/7 ------------------------
    mdu_lat = 1;
    req_op0[0] = MDU_DIV; req_x0[0] = 32'd100; req_y0[0] = 32'd7;
    req_op1[0] = MDU_REM; req_x1[0] = 32'd100; req_y1[0] = 32'd7;
    req_valid[0] = 2'b11;
    #1;
    check("t2 first tie p0", 32'(req_ready[0]), 32'h1);
    step();
    req_valid[0] = 2'b10;
    check("t2 mdu_op div", 32'(mdu_operation[0]), 32'(MDU_DIV));
    wait_rsp(0, 0, n);
    check("t2 min latency", n, 32'd2);
    check("t2 div result", rsp_result[0], 32'd14);
    for (int i = 0; i < 5; i++) begin
      check("t2 stall valid", 32'(rsp_valid[0]), 32'h1);
      check("t2 stall result", rsp_result[0], 32'd14);
      check("t2 stall no ready", 32'(req_ready[0]), 32'h0);
      step();
    end
    rsp_ready[0] = 2'b01;
    req_valid[0] = 2'b11;
    step();
    rsp_ready[0] = 2'b00;
    check("t2 rr grant p1", 32'(req_ready[0]), 32'h2);
    step();
    req_valid[0] = 2'b01;
    wait_rsp(0, 1, n);
    check("t2 rem result", rsp_result[0], 32'd2);
    rsp_ready[0] = 2'b01;
    step();
    check("t2 wrong port ready ignored", 32'(rsp_valid[0]), 32'h2);
    rsp_ready[0] = 2'b10;
    req_valid[0] = 2'b11;
    step();
    rsp_ready[0] = 2'b00;
    check("t2 tie back to p0", 32'(req_ready[0]), 32'h1);
    step();
    req_valid[0] = 2'b00;
    wait_rsp(0, 0, n);
    check("t2 div again", rsp_result[0], 32'd14);
    consume(0, 0);

    // ---- Fixed priority: p0 back-to-back starves p1 ------------------------
    req_op0[1] = MDU_MUL;  req_x0[1] = 32'd3;   req_y0[1] = 32'd5;
    req_op1[1] = MDU_DIVU; req_x1[1] = 32'd100; req_y1[1] = 32'd7;
    req_valid[1] = 2'b11;
    for (int r = 0; r < 3; r++) begin
      #1;
      check("t3 p0 wins", 32'(req_ready[1]), 32'h1);
      step();
      wait_rsp(1, 0, n);
      check("t3 p0 result", rsp_result[1], 32'd15);
      rsp_ready[1] = 2'b01;
      step();
      rsp_ready[1] = 2'b00;
    end
    req_valid[1] = 2'b10;
    #1;
    check("t3 p1 finally", 32'(req_ready[1]), 32'h2);
    step();
    req_valid[1] = 2'b00;
    wait_rsp(1, 1, n);
    check("t3 p1 result", rsp_result[1], 32'd14);
    consume(1, 1);

    // ---- Reset during WAIT, then MULHU on port 1 ---------------------------
    mdu_lat = 5;
    req_op0[0] = MDU_MUL; req_x0[0] = 32'd6; req_y0[0] = 32'd7;
    req_valid[0] = 2'b01;
    #1;
    check("t5 accept", 32'(req_ready[0]), 32'h1);
    step();
    req_valid[0] = 2'b00;
    step();
    check("t5 wait x held", mdu_x[0], 32'd6);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals(0, "t5 async reset");
    step();
    reset = 1'b1;
    step();
    mdu_lat = 2;
    req_op1[0] = MDU_MULHU; req_x1[0] = 32'hFFFF_FFFF; req_y1[0] = 32'd2;
    req_valid[0] = 2'b10;
    #1;
    check("t5 p1 accept", 32'(req_ready[0]), 32'h2);
    step();
    req_valid[0] = 2'b00;
    wait_rsp(0, 1, n);
    check("t5 latency", n, 32'd3);
    check("t5 mulhu result", rsp_result[0], 32'h0000_0001);
    check("t5 one start after reset", g_mdu[0].n_start, 32'd1);
    consume(0, 1);

`ifdef MDU_RESULT_CACHE_EN
    // ---- Result cache: repeat DIVU 50/5, then change y ---------------------
    mdu_lat = 1;
    req_op0[0] = MDU_DIVU; req_x0[0] = 32'd50; req_y0[0] = 32'd5;
    req_valid[0] = 2'b01;
    #1;
    step();
    req_valid[0] = 2'b00;
    wait_rsp(0, 0, n);
    check("c1 miss result", rsp_result[0], 32'd10);
    consume(0, 0);
    starts_before = g_mdu[0].n_start;
    req_valid[0] = 2'b01;
    #1;
    check("c2 accept", 32'(req_ready[0]), 32'h1);
    step();
    req_valid[0] = 2'b00;
    check("c2 hit valid at N+1", 32'(rsp_valid[0]), 32'h1);
    check("c2 hit result", rsp_result[0], 32'd10);
    check("c2 no start", 32'(mdu_start[0]), 32'd0);
    consume(0, 0);
    check("c2 start count", g_mdu[0].n_start, 32'(starts_before));
    req_y0[0] = 32'd6;
    req_valid[0] = 2'b01;
    #1;
    step();
    req_valid[0] = 2'b00;
    check("c3 miss start", 32'(mdu_start[0]), 32'd1);
    wait_rsp(0, 0, n);
    check("c3 result", rsp_result[0], 32'd8);
    consume(0, 0);
`else
    starts_before = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mdu_arbiter
